// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TXDATA are queued in a small FIFO
// and sent as 8N1 frames on tx; STATUS and DROPCNT can be polled.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic        sel,
   output logic [31:0] readdata,
   output logic        tx,
   output logic        irq
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg, state_next;
   logic [BW-1:0] baud_reg, baud_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;
   logic          irq_reg, irq_next;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic [7:0]    drop_reg, drop_next;
   logic [1:0]    offset;
   logic [3:0]    status_count;
   logic          push_req, clr_req, push, pop, full, empty, baud_end;
   logic          unused_bits;

   assign sel          = (dataadr[31:4] == BASE_ADDR[31:4]);
   assign offset       = dataadr[3:2];
   assign push_req     = memwrite && sel && (offset == 2'd0);
   assign clr_req      = memwrite && sel && (offset == 2'd2);
   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign baud_end     = (baud_reg == BAUD_LAST);
   assign status_count = 4'(count_reg);
   assign unused_bits  = &{1'b0, dataadr[1:0], writedata[31:8]};
   assign tx           = tx_reg;
   assign irq          = irq_reg;

   always_comb begin
      readdata = '0;
      if (sel) begin
         case (offset)
            2'd1:    readdata = {20'd0, status_count, 5'd0, empty, full, state_reg != IDLE};
            2'd2:    readdata = {24'd0, drop_reg};
            default: readdata = '0;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_next = fifo_mem[rd_ptr_reg];
               baud_next  = '0;
               state_next = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_next  = '0;
               bit_next   = '0;
               state_next = DATA;
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_next  = '0;
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_reg == 3'd7) state_next = STOP;
               else                 bit_next   = bit_reg + 3'd1;
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_next = '0;
               // Chain straight into the next start bit so frames are contiguous.
               if (!empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_mem[rd_ptr_reg];
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push        = push_req && (!full || pop);
      wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
      rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase

      drop_next = drop_reg;
      if (clr_req)                                      drop_next = '0;
      else if (push_req && !push && drop_reg != 8'hFF) drop_next = drop_reg + 8'd1;

      tx_next = 1'b1;
      if (state_next == START)     tx_next = 1'b0;
      else if (state_next == DATA) tx_next = shift_next[0];
      irq_next = (count_next == '0) && (state_next == IDLE);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= writedata[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         baud_reg   <= '0;
         bit_reg    <= '0;
         shift_reg  <= '0;
         tx_reg     <= 1'b1;
         irq_reg    <= 1'b1;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         drop_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         baud_reg   <= baud_next;
         bit_reg    <= bit_next;
         shift_reg  <= shift_next;
         tx_reg     <= tx_next;
         irq_reg    <= irq_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         drop_reg   <= drop_next;
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register-read table, directed corner sequences and
// random bus traffic, all compared against a frame-timeline model of the UART.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE  = 32'h0000_FF00;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 8;

   logic        clk;
   logic        reset_n;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        sel;
   logic [31:0] readdata;
   logic        tx;
   logic        irq;

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset_n), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .sel(sel), .readdata(readdata), .tx(tx), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: queue of waiting bytes plus the edge at which the current frame began.
   logic [7:0] q[$];
   logic [7:0] m_byte;
   int         m_drop;
   bit         m_active;
   int         m_start;
   int         edge_n;

   logic        last_sel;
   logic [31:0] last_rd;

   typedef struct {
      logic [31:0] adr;
      logic        exp_sel;
      logic [31:0] exp_rd;
   } rd_vec_t;
   rd_vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_drop   = 0;
      m_active = 0;
      m_start  = 0;
      m_byte   = 8'h00;
      edge_n   = 0;
   endfunction

   function automatic bit in_win(logic [31:0] adr);
      return adr[31:4] == BASE[31:4];
   endfunction

   function automatic void model_edge(bit we, logic [31:0] adr, logic [31:0] wd);
      bit pop = 0;
      edge_n++;
      if (!m_active && q.size() > 0) pop = 1;
      else if (m_active && edge_n == m_start + 10 * CPB) begin
         if (q.size() > 0) pop = 1;
         else m_active = 0;
      end
      if (pop) begin
         m_byte   = q.pop_front();
         m_active = 1;
         m_start  = edge_n;
      end
      if (we && in_win(adr) && adr[3:2] == 2'd0) begin
         if (q.size() < DEPTH) q.push_back(wd[7:0]);
         else if (m_drop < 255) m_drop++;
      end
      if (we && in_win(adr) && adr[3:2] == 2'd2) m_drop = 0;
   endfunction

   function automatic logic exp_tx();
      logic [9:0] fr;
      int k;
      if (!m_active) return 1'b1;
      fr = {1'b1, m_byte, 1'b0};
      k  = (edge_n - m_start) / CPB;
      return fr[k];
   endfunction

   function automatic logic exp_irq();
      return (q.size() == 0) && !m_active;
   endfunction

   function automatic logic [31:0] exp_rd(logic [31:0] adr);
      logic [31:0] r;
      r = '0;
      if (in_win(adr)) begin
         if (adr[3:2] == 2'd1) begin
            r      = 32'(q.size()) << 8;
            r[2]   = (q.size() == 0);
            r[1]   = (q.size() == DEPTH);
            r[0]   = m_active;
         end else if (adr[3:2] == 2'd2) begin
            r = 32'(m_drop);
         end
      end
      return r;
   endfunction

   // One bus cycle, entered and left on the falling edge.
   task automatic step(input bit we, input logic [31:0] adr, input logic [31:0] wd);
      memwrite  = we;
      dataadr   = adr;
      writedata = wd;
      if (we) $display("store adr=%08h data=%08h", adr, wd);
      #1;
      last_sel = sel;
      last_rd  = readdata;
      check("sel", {31'd0, sel}, {31'd0, in_win(adr)});
      check("readdata", readdata, exp_rd(adr));
      @(posedge clk);
      model_edge(we, adr, wd);
      @(negedge clk);
      memwrite = 1'b0;
      check("tx", {31'd0, tx}, {31'd0, exp_tx()});
      check("irq", {31'd0, irq}, {31'd0, exp_irq()});
   endtask

   logic [9:0] frame55;
   logic       txs[40];
   bit         seen_low;

   initial begin
      vecs[0] = '{BASE + 32'h0,  1'b1, 32'h0};
      vecs[1] = '{BASE + 32'h4,  1'b1, 32'h4};
      vecs[2] = '{BASE + 32'h7,  1'b1, 32'h4};
      vecs[3] = '{BASE + 32'h8,  1'b1, 32'h0};
      vecs[4] = '{BASE + 32'hC,  1'b1, 32'h0};
      vecs[5] = '{32'd84,        1'b0, 32'h0};
      vecs[6] = '{BASE + 32'h10, 1'b0, 32'h0};
      vecs[7] = '{BASE - 32'h4,  1'b0, 32'h0};

      reset_n   = 1'b0;
      memwrite  = 1'b0;
      dataadr   = 32'd84;
      writedata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_irq", {31'd0, irq}, 32'd1);
      reset_n = 1'b1;

      // Register reads straight out of reset.
      for (int i = 0; i < 8; i++) begin
         step(0, vecs[i].adr, 32'h0);
         check("tbl_sel", {31'd0, last_sel}, {31'd0, vecs[i].exp_sel});
         check("tbl_rd", last_rd, vecs[i].exp_rd);
      end

      // Single byte 0x55: exact line waveform.
      frame55 = {1'b1, 8'h55, 1'b0};
      step(1, BASE, 32'h1234_5A55);
      for (int i = 0; i < 40; i++) begin
         step(0, BASE + 32'h4, 32'h0);
         txs[i] = tx;
         if (i == 1) check("busy_2cyc", {31'd0, last_rd[0]}, 32'd1);
      end
      for (int i = 0; i < 40; i++)
         check("frame55", {31'd0, txs[i]}, {31'd0, frame55[i / CPB]});
      step(0, BASE + 32'h4, 32'h0);
      check("irq_after_stop", {31'd0, irq}, 32'd1);

      // Back-to-back stores.
      step(1, BASE, 32'h41);
      step(1, BASE, 32'h42);
      step(1, BASE, 32'h43);
      step(0, BASE + 32'h4, 32'h0);
      check("b2b_count", {28'd0, last_rd[11:8]}, 32'd2);
      for (int i = 0; i < 125; i++) step(0, BASE + 32'h4, 32'h0);
      check("b2b_idle_irq", {31'd0, irq}, 32'd1);

      // Overflow: ten stores starting from idle.
      for (int i = 0; i < 10; i++) step(1, BASE, 32'(8'hB0 + i));
      step(0, BASE + 32'h4, 32'h0);
      check("ovf_full", {31'd0, last_rd[1]}, 32'd1);
      step(0, BASE + 32'h8, 32'h0);
      check("ovf_drop", last_rd, 32'd1);
      step(1, BASE + 32'h8, 32'hDEAD_BEEF);
      step(0, BASE + 32'h8, 32'h0);
      check("drop_clear", last_rd, 32'd0);
      for (int i = 0; i < 400; i++) step(0, BASE + 32'h4, 32'h0);

      // Drop counter saturation.
      for (int i = 0; i < 310; i++) step(1, BASE, 32'(i));
      step(0, BASE + 32'h8, 32'h0);
      check("drop_sat", last_rd, 32'd255);
      for (int i = 0; i < 400; i++) step(0, BASE + 32'h4, 32'h0);

      // Randomized bus traffic.
      for (int i = 0; i < 1500; i++) begin
         int kind;
         logic [31:0] adr;
         bit we;
         kind = $urandom_range(0, 19);
         we   = (kind < 3);
         if (kind == 19)    adr = $urandom;
         else if (kind < 2) adr = BASE | 32'($urandom_range(0, 3));
         else               adr = BASE | 32'($urandom_range(0, 15));
         step(we, adr, $urandom);
      end
      for (int i = 0; i < 400; i++) step(0, BASE + 32'h4, 32'h0);
      check("rand_drained_irq", {31'd0, irq}, 32'd1);

      // Asynchronous reset during data bit 3 of 0xA5 (bit 3 is 0).
      step(1, BASE, 32'hA5);
      for (int i = 0; i < 19; i++) step(0, BASE + 32'h4, 32'h0);
      check("pre_reset_tx", {31'd0, tx}, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_tx", {31'd0, tx}, 32'd1);
      check("async_irq", {31'd0, irq}, 32'd1);
      check("async_status", readdata, 32'h4);
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      seen_low = 0;
      for (int i = 0; i < 60; i++) begin
         step(0, BASE + 32'h4, 32'h0);
         if (tx !== 1'b1) seen_low = 1;
      end
      check("no_frame_after_reset", {31'd0, seen_low}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped transmit peripheral. It sits on the processor data-memory bus (memwrite/dataadr/writedata) beside dmem and responds to stores and loads in its address window.
- Stored bytes are queued in a small FIFO and serialized as 8N1 UART frames on tx.
- Gives programs a visible output channel, e.g. for pass/fail reporting, and lets software poll status.

Parameters:
- BASE_ADDR, 32'h0000_FF00, byte address of register window. Must be 16-byte aligned.
- CLKS_PER_BIT, 16, clk cycles per UART bit. Must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- memwrite  in  1  store strobe from processor
- dataadr  in  32  byte address from processor
- writedata  in  32  store data from processor
- sel  out  1  combinational: dataadr[31:4]==BASE_ADDR[31:4]; top uses it to mask dmem write and mux readdata
- readdata  out  32  combinational register read data
- tx  out  1  UART line, idle high
- irq  out  1  registered: FIFO empty and transmitter idle

Behaviour:
- Register map, offset = dataadr[3:2]:
  - 0 TXDATA: store pushes writedata[7:0]. Reads return 0.
  - 1 STATUS: read-only. bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bits[11:8] count (0..FIFO_DEPTH), other bits 0.
  - 2 DROPCNT: read returns the 8-bit drop counter, zero-extended. Any store clears it to 0.
  - 3: reserved. Reads return 0; stores ignored.
- Byte offsets dataadr[1:0] are ignored. readdata is 0 when sel==0. Stores act only when memwrite && sel.
- Reset, asserted asynchronously:
  - tx=1, irq=1, FSM=IDLE.
  - FIFO pointers and count=0. DROPCNT=0. Shift register and bit counters cleared.
  - A frame in progress is abandoned; tx returns high immediately.
- FIFO:
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - A push rejected because the FIFO is full increments DROPCNT, saturating at 255.
  - A DROPCNT clear and a drop can never coincide (different offsets).
  - Pointers wrap modulo FIFO_DEPTH. Count tracks simultaneous push and pop correctly (unchanged).
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1. A bit index counts 0..7.
  - IDLE: tx=1. If FIFO not empty: pop head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO is not empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
  - tx is driven from a register, so it is glitch-free.
- Timing:
  - Store into an empty FIFO while IDLE at edge N: empty=1→0 after edge N. State=START and tx=0 after edge N+1.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are contiguous.
- irq: registered. irq=1 iff count==0 && state==IDLE, evaluated on the same edge as the state update.
- Simultaneous store to TXDATA with pop (IDLE or end of STOP): both happen. Count stays unchanged and ordering is preserved.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, release with no stores. Required: tx=1, irq=1, readdata at BASE+4 = 32'h0000_0004 (empty), sel=0 at dataadr=84.
- Single byte, CLKS_PER_BIT=4: store 32'h1234_5A55 to BASE+0. Required:
  - STATUS busy=1 within 2 cycles.
  - tx shows 0, then 1,0,1,0,1,0,1,0 (0x55 LSB first), then 1, each for 4 cycles; 40 cycles total.
  - irq=1 after the stop bit.
- Back-to-back: store 0x41, 0x42, 0x43 on consecutive cycles. Required:
  - Three contiguous frames (120 cycles) with no idle between stop and start.
  - STATUS count reads 2 one cycle after the third store.
- Overflow, FIFO_DEPTH=8: 10 consecutive stores while transmitter busy. Required:
  - full=1, DROPCNT=1 (8 queued + 1 popped at start; 1 drop).
  - A store to BASE+8 then reads DROPCNT=0.
- Saturation: force 300 drops. Required: DROPCNT reads 255.
- Reset mid-frame: assert reset during DATA bit 3. Required: tx=1 immediately (async), count=0, irq=1. After release no further frame is sent.
